// File: rtl/sbox_layer_ctrl.sv
// Runs one 48-bit substitution layer through a single shared S-box, one chunk per clock.
// The S-box is external and must be combinational: sbox_dout is sampled in the cycle sbox_din is driven.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// RUN   | one S-box lookup per cycle, idx 0..NUM_CHUNKS-1
// DONE  | result held on out_data, out_valid=1 until out_ready
module sbox_layer_ctrl #(
  parameter int NUM_CHUNKS = 8,
  parameter int IN_W       = 6,
  parameter int OUT_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CHUNKS*IN_W-1:0]  in_data,
  output logic [IN_W-1:0]             sbox_din,
  input  logic [OUT_W-1:0]            sbox_dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CHUNKS*OUT_W-1:0] out_data,
  output logic                        busy
);

  localparam int SRC_W = NUM_CHUNKS * IN_W;
  localparam int ACC_W = NUM_CHUNKS * OUT_W;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sbox_din  = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
          src_d   = in_data;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        // MSB chunk goes first so results shift into acc in the same order
        sbox_din = src_q[SRC_W-1 -: IN_W];
        acc_d    = {acc_q[ACC_W-OUT_W-1:0], sbox_dout};
        src_d    = src_q << IN_W;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data = acc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_layer_ctrl.sv
// Self-checking bench for sbox_layer_ctrl with a stub S-box (dout = din[4:1]).
// Directed vectors, multi-cycle corner sequences, and a randomized run against a cycle model.
module tb_sbox_layer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic [5:0]  sbox_din;
  logic [3:0]  sbox_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  sbox_layer_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sbox_din  (sbox_din),
    .sbox_dout (sbox_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  assign sbox_dout = sbox_din[4:1];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] stub_word(input logic [47:0] w);
    logic [31:0] r;
    logic [5:0]  c;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      c = w[47-6*k -: 6];
      r[31-4*k -: 4] = c[4:1];
    end
    return r;
  endfunction

  // Full transaction from IDLE with out_ready high: accept, 8 RUN cycles, DONE, back to IDLE.
  task automatic run_word(input logic [47:0] din, input logic [31:0] exp);
    logic [47:0] w;
    w = din;
    check("idle_in_ready", in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    for (int t = 0; t < 8; t++) begin
      check("run_sbox_din", sbox_din, w[47-6*t -: 6]);
      check("run_out_valid", out_valid, 1'b0);
      check("run_in_ready", in_ready, 1'b0);
      check("run_busy", busy, 1'b1);
      tick();
    end
    check("done_out_valid", out_valid, 1'b1);
    check("done_out_data", out_data, exp);
    check("done_sbox_din", sbox_din, 6'd0);
    tick();
    check("after_in_ready", in_ready, 1'b1);
    check("after_out_valid", out_valid, 1'b0);
    check("after_busy", busy, 1'b0);
  endtask

  task automatic random_run(input int ncycles);
    int          phase;
    logic [47:0] cur;
    logic [31:0] exp_q[$];
    logic        accepted;
    phase    = 0;
    cur      = '0;
    accepted = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      if (accepted || !in_valid) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = {16'($urandom), 32'($urandom)};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      check("rnd_in_ready", in_ready, phase == 0);
      check("rnd_out_valid", out_valid, phase == 9);
      check("rnd_busy", busy, phase != 0);
      if (phase >= 1 && phase <= 8)
        check("rnd_sbox_din", sbox_din, cur[47-6*(phase-1) -: 6]);
      else
        check("rnd_sbox_idle", sbox_din, 6'd0);
      if (phase == 9) begin
        if (exp_q.size() == 0) check("rnd_unexpected_out", 1'b1, 1'b0);
        else check("rnd_out_data", out_data, exp_q[0]);
      end
      accepted = 1'b0;
      if (phase == 0) begin
        if (in_valid) begin
          exp_q.push_back(stub_word(in_data));
          cur      = in_data;
          phase    = 1;
          accepted = 1'b1;
        end
      end else if (phase <= 8) begin
        phase++;
      end else if (out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        phase = 0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
  endtask

  initial begin
    logic [31:0] held;
    logic [47:0] wa, wb;
    int          acc_cyc[$];
    int          outs;

    vecs[0] = '{48'hFFF000FFF000, 32'hFF00FF00};
    vecs[1] = '{48'h79E79E79E79E, 32'hFFFFFFFF};
    vecs[2] = '{48'h000000000000, 32'h00000000};
    vecs[3] = '{48'hFFFFFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{48'h555555555555, 32'hAAAAAAAA};
    vecs[5] = '{48'hAAAAAAAAAAAA, 32'h55555555};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_sbox_din", sbox_din, 6'h0);

    for (int i = 0; i < 6; i++) run_word(vecs[i].din, vecs[i].exp);

    // Backpressure: result held, new words refused.
    in_valid  = 1'b1;
    in_data   = 48'h123456789ABC;
    out_ready = 1'b0;
    tick();
    in_data = 48'hFEDCBA987654;
    for (int t = 0; t < 8; t++) tick();
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_out_data", out_data, stub_word(48'h123456789ABC));
    held = out_data;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, held);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_idle", in_ready, 1'b1);
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_valid", out_valid, 1'b0);

    // Reset at idx=4 during RUN.
    in_valid = 1'b1;
    in_data  = 48'hFFFFFFFFFFFF;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 4; t++) tick();
    check("mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 32'h0);
    check("mid_rst_sbox_din", sbox_din, 6'h0);
    run_word(48'h0, 32'h0);

    // Reset while DONE discards the pending result.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 48'hFFF000FFF000;
    tick();
    in_valid = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    check("done_rst_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("done_rst_out_valid", out_valid, 1'b0);
    check("done_rst_out_data", out_data, 32'h0);
    check("done_rst_busy", busy, 1'b0);

    // Reset and in_valid together: nothing captured.
    in_valid = 1'b1;
    in_data  = 48'hFFFFFFFFFFFF;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("rst_valid_busy", busy, 1'b0);
    check("rst_valid_in_ready", in_ready, 1'b1);
    tick();
    check("rst_valid_busy2", busy, 1'b0);

    // Back-to-back with in_valid held high.
    wa = 48'h0F3C5A96E1D2;
    wb = 48'h87654321ABCD;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = wa;
    outs      = 0;
    for (int c = 0; c < 40; c++) begin
      logic acc_now;
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("b2b_out_data", out_data, (outs == 0) ? stub_word(wa) : stub_word(wb));
        outs++;
      end
      if (acc_now) acc_cyc.push_back(c);
      tick();
      if (acc_now && acc_cyc.size() == 1) in_data = wb;
      if (acc_now && acc_cyc.size() == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_accepts", acc_cyc.size(), 2);
    check("b2b_outputs", outs, 2);
    if (acc_cyc.size() == 2) check("b2b_spacing", acc_cyc[1] - acc_cyc[0], 10);

    random_run(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
